// File: rtl/qtestpd_onchip_mem_arbiter_pkg.sv
// Shared types and sizes for the two-master on-chip RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package qtestpd_mem_arb_pkg;

  localparam int MEM_ADDR_W = 7;
  localparam int MEM_DATA_W = 8;
  localparam int DEPTH      = 2**MEM_ADDR_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Master index: 0 = m0, 1 = m1
  typedef logic mst_t;

  localparam mst_t MST0 = 1'b0;
  localparam mst_t MST1 = 1'b1;

endpackage

// File: rtl/qtestpd_onchip_mem_arbiter_rr.sv
// Two-way round-robin picker: one-hot grant from two requests and the last winner.
// Latency: purely combinational.
// Backpressure: a losing requester simply sees no grant; nothing is queued here.
module qtestpd_rr_arb2
  import qtestpd_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_t       last_grant,
  output logic [1:0] grant
);

  // Lone requester wins; on a tie the master that did not win last time goes next
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == MST1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/qtestpd_onchip_mem_arbiter.sv
// Round-robin arbiter/sequencer for two Avalon-MM masters sharing a 1-cycle-latency single-port RAM.
// Latency: grant is combinational; read data returns with readdatavalid 1 cycle after acceptance.
// Backpressure: a non-granted requester sees waitrequest=1; optional power-up clear (QTESTPD_MEM_ARB_INIT_CLEAR_EN) stalls both masters while busy.
module qtestpd_onchip_mem_arbiter
  import qtestpd_mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy
);

  state_t            state;
  logic              run;
  logic [1:0]        req;
  logic [1:0]        arb_req;
  logic [1:0]        grant;
  mst_t              last_grant;
  mst_t              rd_owner;
  logic              rd_pend;
  logic              rd_acc;
  logic [ADDR_W-1:0] clr_addr;

`ifdef QTESTPD_MEM_ARB_INIT_CLEAR_EN
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;

  // State register: reset lands in INIT so the RAM gets wiped before use
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  // Leave INIT right after the write to the last address
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (&clr_cnt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Clear address walks every RAM word once while in INIT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            clr_cnt <= '0;
    else if (state == INIT)  clr_cnt <= clr_cnt + ADDR_W'(1);
  end

  assign clr_addr = clr_cnt;
  assign busy     = (state == INIT);
`else
  assign state    = RUN;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  assign run     = (state == RUN);
  // A write takes priority when a master raises read and write together
  assign req     = {m1_read | m1_write, m0_read | m0_write};
  assign arb_req = req & {2{run}};

  qtestpd_rr_arb2 u_rr_arb2 (
    .req        (arb_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];

  assign rd_acc = (grant[0] & m0_read & ~m0_write) |
                  (grant[1] & m1_read & ~m1_write);

  // RAM port mux: clear engine in INIT, otherwise the granted master
  always_comb begin
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    if (!run) begin
      mem_address    = clr_addr;
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end else if (grant[0]) begin
      mem_address    = m0_address;
      mem_chipselect = 1'b1;
      mem_write      = m0_write;
      mem_writedata  = m0_writedata;
    end else if (grant[1]) begin
      mem_address    = m1_address;
      mem_chipselect = 1'b1;
      mem_write      = m1_write;
      mem_writedata  = m1_writedata;
    end
  end

  // Track the read in flight and the round-robin history; m0 wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend    <= 1'b0;
      rd_owner   <= MST0;
      last_grant <= MST1;
    end else begin
      rd_pend <= rd_acc;
      if (rd_acc)  rd_owner   <= grant[1];
      if (|grant)  last_grant <= grant[1];
    end
  end

  assign m0_readdatavalid = rd_pend & (rd_owner == MST0);
  assign m1_readdatavalid = rd_pend & (rd_owner == MST1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign mem_clken        = 1'b1;

endmodule

// File: tb/tb_qtestpd_onchip_mem_arbiter.sv
`timescale 1ns/1ps
module tb_qtestpd_onchip_mem_arbiter;

`ifdef QTESTPD_MEM_ARB_INIT_CLEAR_EN
  localparam logic CLR = 1'b1;
`else
  localparam logic CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] m0_address, m1_address;
  logic       m0_read, m0_write, m1_read, m1_write;
  logic [7:0] m0_writedata, m1_writedata;
  logic       m0_waitrequest, m1_waitrequest;
  logic [7:0] m0_readdata, m1_readdata;
  logic       m0_readdatavalid, m1_readdatavalid;
  logic [6:0] mem_address;
  logic       mem_chipselect, mem_write, mem_clken;
  logic [7:0] mem_writedata;
  logic [7:0] mem_readdata;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qtestpd_onchip_mem_arbiter dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata),
    .busy             (busy)
  );

  // 128x8 single-port RAM, registered read (old data on same-cycle write)
  logic [7:0] ram [0:127];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) ram[mem_address] <= mem_writedata;
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      cyc();
    end
  endtask

  int nbusy;
  int cnt0, cnt1;

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (2) cyc();

    // Reset state
    chk("rst_m0_rdv",  m0_readdatavalid, 0);
    chk("rst_m1_rdv",  m1_readdatavalid, 0);
    chk("rst_m0_wait", m0_waitrequest, 0);
    chk("rst_busy",    busy, CLR);
    chk("rst_cs",      mem_chipselect, CLR);
    chk("rst_clken",   mem_clken, 1);

    // 1: release reset, optional clear walk
    reset_n = 1'b1;
    m0_read = 1'b1; m0_address = 7'h33;
    #1;
    chk("init_wait", m0_waitrequest, CLR);
    chk("init_wr",   mem_write, CLR);
    m0_read = 1'b0;
    #1;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 200) begin
      if (nbusy < 128) chk("init_addr", mem_address, nbusy);
      nbusy++;
      cyc();
    end
    chk("init_cycles", nbusy, CLR ? 128 : 0);
    chk("init_done",   busy, 0);

    m0_read = 1'b1; m0_address = 7'h7F;
    #1;
    chk("t1_wait", m0_waitrequest, 0);
    cyc();
    idle();
    chk("t1_rdv", m0_readdatavalid, 1);
`ifdef QTESTPD_MEM_ARB_INIT_CLEAR_EN
    chk("t1_data", m0_readdata, 8'h00);
`endif
    cyc();

    // 2: m0 write then read back
    m0_write = 1'b1; m0_address = 7'h10; m0_writedata = 8'hA5;
    #1;
    chk("t2_wait",  m0_waitrequest, 0);
    chk("t2_cs",    mem_chipselect, 1);
    chk("t2_mwr",   mem_write, 1);
    chk("t2_maddr", mem_address, 7'h10);
    chk("t2_mwd",   mem_writedata, 8'hA5);
    cyc();
    m0_write = 1'b0; m0_read = 1'b1;
    #1;
    chk("t2_rd_mwr", mem_write, 0);
    chk("t2_rdv_early", m0_readdatavalid, 0);
    cyc();
    idle();
    chk("t2_rdv",    m0_readdatavalid, 1);
    chk("t2_data",   m0_readdata, 8'hA5);
    chk("t2_m1_rdv", m1_readdatavalid, 0);
    cyc();
    chk("t2_rdv_end", m0_readdatavalid, 0);

    // Seed data for test 3; last access by m1 so the next tie goes to m0
    m0_write = 1'b1; m0_address = 7'h01; m0_writedata = 8'h11;
    cyc();
    idle();
    m1_write = 1'b1; m1_address = 7'h02; m1_writedata = 8'h22;
    cyc();
    idle();

    // 3: both read continuously, grants alternate from m0
    m0_read = 1'b1; m0_address = 7'h01;
    m1_read = 1'b1; m1_address = 7'h02;
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t3_m0_wait", m0_waitrequest, (k % 2 == 1));
      chk("t3_m1_wait", m1_waitrequest, (k % 2 == 0));
      chk("t3_maddr",   mem_address, (k % 2 == 0) ? 7'h01 : 7'h02);
      cyc();
      chk("t3_m0_rdv", m0_readdatavalid, (k % 2 == 0));
      chk("t3_m1_rdv", m1_readdatavalid, (k % 2 == 1));
      chk("t3_data",   m0_readdata, (k % 2 == 0) ? 8'h11 : 8'h22);
      if (m0_readdatavalid === 1'b1) cnt0++;
      if (m1_readdatavalid === 1'b1) cnt1++;
    end
    idle();
    chk("t3_cnt0", cnt0, 4);
    chk("t3_cnt1", cnt1, 4);
    cyc();
    chk("t3_quiet", {m0_readdatavalid, m1_readdatavalid}, 2'b00);

    // 4: m0 write and m1 read of the same address in the same cycle
    m0_write = 1'b1; m0_address = 7'h20; m0_writedata = 8'h3C;
    m1_read  = 1'b1; m1_address = 7'h20;
    #1;
    chk("t4_m0_wait", m0_waitrequest, 0);
    chk("t4_m1_wait", m1_waitrequest, 1);
    chk("t4_mwr",     mem_write, 1);
    cyc();
    m0_write = 1'b0;
    #1;
    chk("t4_m1_wait2", m1_waitrequest, 0);
    chk("t4_mwr2",     mem_write, 0);
    cyc();
    idle();
    chk("t4_m1_rdv",  m1_readdatavalid, 1);
    chk("t4_data",    m1_readdata, 8'h3C);
    chk("t4_m0_rdv",  m0_readdatavalid, 0);
    cyc();

    // 5: reset right after a read acceptance drops the return
    m0_read = 1'b1; m0_address = 7'h10;
    cyc();
    m0_read = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t5_rdv_drop", m0_readdatavalid, 0);
    cyc();
    chk("t5_rdv_next", m0_readdatavalid, 0);
    reset_n = 1'b1;
    #1;
    chk("t5_m1_rdv", m1_readdatavalid, 0);
    chk("t5_busy",   busy, CLR);
    wait_busy(nbusy);
    chk("t5_init_cycles", nbusy, CLR ? 128 : 0);
    // last_grant back at reset value: tie goes to m0
    m0_read = 1'b1; m0_address = 7'h10;
    m1_read = 1'b1; m1_address = 7'h20;
    #1;
    chk("t5_m0_wait", m0_waitrequest, 0);
    chk("t5_m1_wait", m1_waitrequest, 1);
    cyc();
    idle();
    chk("t5_m0_rdv", m0_readdatavalid, 1);
    cyc();

    // 6: only m1 writes for 16 cycles, never stalled
    for (int k = 0; k < 16; k++) begin
      m1_write = 1'b1; m1_address = 7'h40 + 7'(k); m1_writedata = 8'(k);
      #1;
      chk("t6_m1_wait", m1_waitrequest, 0);
      chk("t6_maddr",   mem_address, 7'h40 + 7'(k));
      chk("t6_m0_out",  {m0_waitrequest, m0_readdatavalid}, 2'b00);
      cyc();
    end
    idle();
    m0_read = 1'b1; m0_address = 7'h45;
    cyc();
    idle();
    chk("t6_rb_rdv",  m0_readdatavalid, 1);
    chk("t6_rb_data", m0_readdata, 8'h05);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
